// File: rtl/stream_mux_rr.sv
// Registered N-to-1 stream multiplexer with valid/ready handshakes and packet-locked arbitration.
// Modes: 0/3 round-robin, 1 fixed lowest-index priority, 2 forced channel.
module stream_mux_rr #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode,
    input  logic [SEL_W-1:0]        force_sel,
    input  logic [N_CH-1:0]         in_valid,
    output logic [N_CH-1:0]         in_ready,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [N_CH-1:0]         in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_last,
    output logic [SEL_W-1:0]        out_ch
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [SEL_W-1:0]   lock_ch, lock_ch_nxt;
    logic [SEL_W-1:0]   grant_ch, sel_ch, rr_idx;
    logic               grant_valid, can_load, load;
    logic [WIDTH-1:0]   sel_data;
    logic               sel_last;
    logic [(1<<SEL_W)-1:0] valid_ext;

    assign can_load = !out_valid || out_ready;
    assign sel_ch   = (state == LOCKED) ? lock_ch : grant_ch;
    assign load     = |(in_valid & in_ready);

    // Idle-state grant; the widened valid vector keeps out-of-range force_sel values from granting.
    always_comb begin
        valid_ext = '0;
        valid_ext[N_CH-1:0] = in_valid;
        grant_valid = 1'b0;
        grant_ch    = '0;
        rr_idx      = '0;
        case (mode)
            2'd1: begin
                for (int i = N_CH - 1; i >= 0; i--) begin
                    if (valid_ext[SEL_W'(i)]) begin
                        grant_valid = 1'b1;
                        grant_ch    = SEL_W'(i);
                    end
                end
            end
            2'd2: begin
                if (valid_ext[force_sel]) begin
                    grant_valid = 1'b1;
                    grant_ch    = force_sel;
                end
            end
            default: begin
                for (int k = N_CH; k >= 1; k--) begin
                    rr_idx = SEL_W'((int'(rr_ptr) + k) % N_CH);
                    if (valid_ext[rr_idx]) begin
                        grant_valid = 1'b1;
                        grant_ch    = rr_idx;
                    end
                end
            end
        endcase
    end

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel_ch == SEL_W'(i)) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
                sel_last = in_last[i];
            end
        end
    end

    // State register plus the output beat register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= SEL_W'(N_CH - 1);
            lock_ch   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else begin
            state   <= state_nxt;
            rr_ptr  <= rr_ptr_nxt;
            lock_ch <= lock_ch_nxt;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_last  <= sel_last;
                out_ch    <= sel_ch;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // The pointer only moves at packet end so fairness counts packets, not beats.
    always_comb begin
        state_nxt   = state;
        rr_ptr_nxt  = rr_ptr;
        lock_ch_nxt = lock_ch;
        if (load) begin
            case (state)
                IDLE: begin
                    if (sel_last) begin
                        rr_ptr_nxt = sel_ch;
                    end else begin
                        state_nxt   = LOCKED;
                        lock_ch_nxt = sel_ch;
                    end
                end
                LOCKED: begin
                    if (sel_last) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = lock_ch;
                    end
                end
            endcase
        end
    end

    always_comb begin
        in_ready = '0;
        if (!rst) begin
            if (state == LOCKED) begin
                in_ready[lock_ch] = can_load;
            end else if (grant_valid) begin
                in_ready[grant_ch] = can_load;
            end
        end
    end

endmodule
